// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory responder: FSM encoding,
// NOP filler word, latency counter width and an address range helper.
package imem_pkg;

  localparam int          CNT_W    = 4;
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // A byte address maps to storage only if it is at or above the base and its
  // word index falls inside the array.
  function automatic logic addr_in_range(input logic [31:0] addr,
                                         input logic [31:0] base,
                                         input int unsigned words);
    logic [31:0] offset;
    offset = addr - base;
    return (addr >= base) && ({2'b00, offset[31:2]} < words);
  endfunction

endpackage

// File: rtl/imem_array.sv
// Backing storage: MEM_WORDS x 32, one synchronous write port and one
// combinational read port, so a same-edge write is never seen by the reader.
module imem_array
  import imem_pkg::*;
#(
  parameter int MEM_WORDS = 1024,
  parameter int AW        = $clog2(MEM_WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [MEM_WORDS];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/imem_responder.sv
// Fixed-latency instruction memory responder with preload port.
// Define IMEM_STATS_EN to add saturating request/busy statistics outputs.
module imem_responder
  import imem_pkg::*;
#(
  parameter int          MEM_WORDS = 1024,
  parameter int          LATENCY   = 2,
  parameter logic [31:0] ADDR_BASE = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_req_valid,
  input  logic [31:0] mem_req_addr,
  output logic        mem_req_ready,
  output logic [31:0] mem_req_rdata,
  input  logic        load_en,
  input  logic [31:0] load_addr,
  input  logic [31:0] load_data,
  output logic        err_range
`ifdef IMEM_STATS_EN
  ,
  output logic [31:0] stat_reqs,
  output logic [31:0] stat_busy
`endif
);

  localparam int AW = $clog2(MEM_WORDS);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [31:0]      data_reg, data_next;
  logic             err_reg, err_next;

  logic [AW-1:0] req_idx, load_idx;
  logic          req_ok, load_ok;
  logic [31:0]   rd_word;

  assign req_idx  = AW'((mem_req_addr - ADDR_BASE) >> 2);
  assign load_idx = AW'((load_addr - ADDR_BASE) >> 2);
  assign req_ok   = addr_in_range(mem_req_addr, ADDR_BASE, MEM_WORDS);
  assign load_ok  = addr_in_range(load_addr, ADDR_BASE, MEM_WORDS);

  // Loads are honoured in every state, including while reset is asserted.
  imem_array #(
    .MEM_WORDS (MEM_WORDS),
    .AW        (AW)
  ) u_array (
    .clk   (clk),
    .we    (load_en & load_ok),
    .waddr (load_idx),
    .wdata (load_data),
    .raddr (req_idx),
    .rdata (rd_word)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      data_reg  <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      data_reg  <= data_next;
      err_reg   <= err_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    data_next  = data_reg;
    err_next   = err_reg;
    case (state_reg)
      IDLE: begin
        if (mem_req_valid) begin
          // Data is sampled from the array before any same-edge load lands.
          cnt_next   = CNT_W'(LATENCY - 1);
          data_next  = req_ok ? rd_word : NOP_INSN;
          err_next   = ~req_ok;
          state_next = (LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_next = cnt_reg - CNT_W'(1);
        if (cnt_reg <= CNT_W'(1)) state_next = RESP;
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign mem_req_ready = (state_reg == RESP);
  assign mem_req_rdata = mem_req_ready ? data_reg : 32'h0;
  assign err_range     = mem_req_ready & err_reg;

`ifdef IMEM_STATS_EN
  logic [31:0] stat_reqs_reg, stat_busy_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_reqs_reg <= '0;
      stat_busy_reg <= '0;
    end else begin
      if (state_reg == IDLE && mem_req_valid && stat_reqs_reg != 32'hFFFF_FFFF)
        stat_reqs_reg <= stat_reqs_reg + 32'd1;
      if ((state_reg == WAIT || state_reg == RESP) && stat_busy_reg != 32'hFFFF_FFFF)
        stat_busy_reg <= stat_busy_reg + 32'd1;
    end
  end

  assign stat_reqs = stat_reqs_reg;
  assign stat_busy = stat_busy_reg;
`endif

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder at default parameters (LATENCY=2,
// MEM_WORDS=1024, ADDR_BASE=0); statistics checks appear with IMEM_STATS_EN.
module tb_imem_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_req_valid = 1'b0;
  logic [31:0] mem_req_addr = 32'h0;
  logic        mem_req_ready;
  logic [31:0] mem_req_rdata;
  logic        load_en = 1'b0;
  logic [31:0] load_addr = 32'h0;
  logic [31:0] load_data = 32'h0;
  logic        err_range;
`ifdef IMEM_STATS_EN
  logic [31:0] stat_reqs;
  logic [31:0] stat_busy;
`endif

  int total = 0;
  int passed = 0;
  int pulse_cnt = 0;
  int p0;

  imem_responder dut (
    .clk           (clk),
    .reset         (reset),
    .mem_req_valid (mem_req_valid),
    .mem_req_addr  (mem_req_addr),
    .mem_req_ready (mem_req_ready),
    .mem_req_rdata (mem_req_rdata),
    .load_en       (load_en),
    .load_addr     (load_addr),
    .load_data     (load_data),
    .err_range     (err_range)
`ifdef IMEM_STATS_EN
    ,
    .stat_reqs     (stat_reqs),
    .stat_busy     (stat_busy)
`endif
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!reset && mem_req_ready) pulse_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h required %h", tag, obs, exp);
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] d);
    load_en = 1'b1; load_addr = a; load_data = d;
    tick;
    load_en = 1'b0;
  endtask

  // One controller-paced read; an optional load is applied at the acceptance edge.
  task automatic read(input string tag, input logic [31:0] a, input logic [31:0] exp_d,
                      input logic exp_err, input logic ld, input logic [31:0] ld_a,
                      input logic [31:0] ld_d);
    int cyc;
    mem_req_valid = 1'b1; mem_req_addr = a;
    load_en = ld; load_addr = ld_a; load_data = ld_d;
    tick;
    load_en = 1'b0;
    cyc = 1;
    check({tag, "_wait_rdata"}, mem_req_rdata, 32'h0);
    while (!mem_req_ready && cyc < 20) begin
      tick;
      cyc++;
    end
    check({tag, "_latency"}, cyc, 32'd2);
    check({tag, "_rdata"}, mem_req_rdata, exp_d);
    check({tag, "_err"}, {31'b0, err_range}, {31'b0, exp_err});
    tick;
    mem_req_valid = 1'b0;
    check({tag, "_no_dup"}, {31'b0, mem_req_ready}, 32'h0);
  endtask

  initial begin
    tick;
    tick;
    check("rst_ready", {31'b0, mem_req_ready}, 32'h0);
    check("rst_rdata", mem_req_rdata, 32'h0);
    check("rst_err", {31'b0, err_range}, 32'h0);

    // Preload while reset is still asserted.
    load(32'h14, 32'hDEAD_BEEF);
    load(32'h0C, 32'h0000_00A5);
    for (int i = 0; i < 4; i++) load(32'h40 + 4 * i, 32'h1000_0040 + 4 * i);
    load(32'hFFC, 32'h0FFC_0FFC);
    load(32'h0, 32'h1111_1111);
    load(32'h1000, 32'hBAD0_BAD0);
    reset = 1'b0;
    tick;

    read("basic", 32'h14, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0, 32'h0);
    read("lowbits", 32'h17, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0, 32'h0);

    p0 = pulse_cnt;
    read("burst0", 32'h40, 32'h1000_0040, 1'b0, 1'b0, 32'h0, 32'h0);
    read("burst1", 32'h44, 32'h1000_0044, 1'b0, 1'b0, 32'h0, 32'h0);
    read("burst2", 32'h48, 32'h1000_0048, 1'b0, 1'b0, 32'h0, 32'h0);
    read("burst3", 32'h4C, 32'h1000_004C, 1'b0, 1'b0, 32'h0, 32'h0);
    tick;
    tick;
    check("burst_pulses", pulse_cnt - p0, 32'd4);

    read("oor", 32'h1000, 32'h0000_0013, 1'b1, 1'b0, 32'h0, 32'h0);
    read("last_word", 32'hFFC, 32'h0FFC_0FFC, 1'b0, 1'b0, 32'h0, 32'h0);
    read("oor_load_dropped", 32'h0, 32'h1111_1111, 1'b0, 1'b0, 32'h0, 32'h0);

    read("collide_old", 32'h0C, 32'h0000_00A5, 1'b0, 1'b1, 32'h0C, 32'h1);
    read("collide_new", 32'h0C, 32'h0000_0001, 1'b0, 1'b0, 32'h0, 32'h0);

    // A load landing while the read waits must not alter the response.
    mem_req_valid = 1'b1; mem_req_addr = 32'h14;
    tick;
    load_en = 1'b1; load_addr = 32'h14; load_data = 32'h2222_2222;
    tick;
    load_en = 1'b0;
    check("wait_load_ready", {31'b0, mem_req_ready}, 32'h1);
    check("wait_load_rdata", mem_req_rdata, 32'hDEAD_BEEF);
    tick;
    mem_req_valid = 1'b0;
    read("after_wait_load", 32'h14, 32'h2222_2222, 1'b0, 1'b0, 32'h0, 32'h0);

    // Reset in the middle of WAIT discards the pending response.
    p0 = pulse_cnt;
    mem_req_valid = 1'b1; mem_req_addr = 32'h14;
    tick;
    mem_req_valid = 1'b0;
    reset = 1'b1;
    tick;
    check("midrst_ready", {31'b0, mem_req_ready}, 32'h0);
    check("midrst_rdata", mem_req_rdata, 32'h0);
    check("midrst_err", {31'b0, err_range}, 32'h0);
    reset = 1'b0;
    tick;
    tick;
    tick;
    check("midrst_no_pulse", pulse_cnt - p0, 32'd0);
    read("after_rst", 32'h14, 32'h2222_2222, 1'b0, 1'b0, 32'h0, 32'h0);

`ifdef IMEM_STATS_EN
    reset = 1'b1;
    tick;
    reset = 1'b0;
    check("stat_reqs_rst", stat_reqs, 32'd0);
    check("stat_busy_rst", stat_busy, 32'd0);
    read("stat0", 32'h40, 32'h1000_0040, 1'b0, 1'b0, 32'h0, 32'h0);
    read("stat1", 32'h44, 32'h1000_0044, 1'b0, 1'b0, 32'h0, 32'h0);
    read("stat2", 32'h48, 32'h1000_0048, 1'b0, 1'b0, 32'h0, 32'h0);
    tick;
    check("stat_reqs", stat_reqs, 32'd3);
    check("stat_busy", stat_busy, 32'd6);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/imem_responder.md
IMEM_RESPONDER -- requirements
Module: imem_responder

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 1024, meaning the number of 32-bit words in backing storage (power of two, at least 4).
REQ-002 SHALL have parameter LATENCY, default 2, meaning the number of cycles from request acceptance to the ready pulse (1..15).
REQ-003 SHALL have parameter ADDR_BASE, default 32'h0000_0000, meaning the byte address of word 0.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port mem_req_valid, input, 1 bit: read request from the fetch controller.
REQ-007 SHALL have port mem_req_addr, input, 32 bits: byte address, valid while mem_req_valid is high.
REQ-008 SHALL have port mem_req_ready, output, 1 bit: one-cycle pulse; mem_req_rdata is valid in the same cycle.
REQ-009 SHALL have port mem_req_rdata, output, 32 bits: read data.
REQ-010 SHALL have port load_en, input, 1 bit: preload write strobe.
REQ-011 SHALL have port load_addr, input, 32 bits: preload byte address.
REQ-012 SHALL have port load_data, input, 32 bits: preload word.
REQ-013 SHALL have port err_range, output, 1 bit: pulse with mem_req_ready when the request address was out of range.

Function
REQ-014 SHALL implement the state machine IDLE -> WAIT -> RESP -> IDLE.
REQ-015 SHALL, in IDLE with mem_req_valid high at edge t, capture the word index ((addr-ADDR_BASE)>>2), latch the read data and range flag, and load the counter with LATENCY-1.
REQ-016 SHALL hold mem_req_ready high for exactly cycle t+LATENCY, in state RESP, with mem_req_rdata equal to the data latched at edge t.
REQ-017 SHALL, when LATENCY=1, go IDLE -> RESP directly.
REQ-018 SHALL, in WAIT, decrement the counter every cycle and enter RESP when it reaches 0.
REQ-019 SHALL ignore mem_req_valid in WAIT and RESP, so a valid still high during the ready cycle never starts a second transaction.
REQ-020 SHALL ignore address bits [1:0].
REQ-021 SHALL treat an address below ADDR_BASE or a word index of MEM_WORDS or more as out of range; such a request returns 32'h0000_0013 (NOP) with err_range=1 and takes the same latency.
REQ-022 SHALL drive mem_req_rdata to 0 whenever mem_req_ready is low.
REQ-023 SHALL accept load_en in every state; a load to an in-range address writes at the edge, and a load to an out-of-range address is dropped.
REQ-024 SHALL, when a load and a read acceptance hit the same word at the same edge, return the old word to the read, since data is latched before the write.
REQ-025 SHALL, once a read is accepted, be unaffected by later loads.
REQ-026 SHALL produce back-to-back requests at the controller's pace (valid low one cycle after ready) without a lost or duplicated pulse.

Reset
REQ-027 SHALL, when reset is high at an edge, force IDLE, mem_req_ready=0, mem_req_rdata=0, err_range=0, counter=0 and all statistics to 0, including mid-WAIT or in RESP, where the pending response is discarded.
REQ-028 SHALL retain storage contents across reset.
REQ-029 SHALL accept loads while reset is high.

Configuration
REQ-030 SHALL, when IMEM_STATS_EN is defined, add output stat_reqs (32 bits, accepted reads) and output stat_busy (32 bits, cycles in WAIT or RESP), both saturating at 32'hFFFF_FFFF.
REQ-031 SHALL, when IMEM_STATS_EN is undefined, omit the statistics ports and counters entirely, with all other behaviour identical.

Structure
REQ-032 SHALL place the state encoding (IDLE, WAIT, RESP), the NOP constant 32'h0000_0013 and the counter width of 4 bits in shared package imem_pkg.
REQ-033 SHALL place storage in sub-module imem_array, which has one synchronous write port and one combinational read port of MEM_WORDS x 32.

Verification
REQ-034 SHALL cover: with LATENCY=2, preload word 5 with 32'hDEADBEEF, then valid with addr 32'h14 at edge t -> ready and rdata=32'hDEADBEEF only in cycle t+2, err_range=0.
REQ-035 SHALL cover: the controller pattern of 4 consecutive words at 32'h40..32'h4C -> exactly 4 ready pulses, correct data each, and no extra pulse while valid is still high in a ready cycle.
REQ-036 SHALL cover: addr 32'h0000_1000 with MEM_WORDS=1024 -> rdata=32'h0000_0013 with err_range=1 after LATENCY cycles.
REQ-037 SHALL cover: a load of 32'h1 to word 3 at the same edge as a read acceptance of word 3 (old value 32'hA5) -> response 32'hA5, and a subsequent read returns 32'h1.
REQ-038 SHALL cover: reset pulsed during WAIT -> no ready pulse, outputs 0, and the next request is served normally with its data intact.
REQ-039 SHALL cover, with IMEM_STATS_EN defined: 3 reads at LATENCY=2 -> stat_reqs=3 and stat_busy=6.
